// File: rtl/array_bus_merge.sv
// array_bus_merge: merges two valid-only byte lanes into one ready/valid stream.
// Each lane feeds its own FIFO. A round-robin arbiter drains the FIFOs into a
// registered output that is tagged with the source lane. A sticky overflow flag
// per lane records that a word arrived while that lane's FIFO was full.
// Optional feature macro: ARRAY_MERGE_STATS_EN adds saturating per-lane drop counters.
// DEPTH must be a power of 2 and at least 2 so that the pointers wrap naturally.
module array_bus_merge #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data  [0:1],
   input  logic              in_valid [0:1],
   output logic [DATA_W-1:0] out_data,
   output logic              out_lane,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow [0:1]
`ifdef ARRAY_MERGE_STATS_EN
   ,
   output logic [15:0]       drop_cnt [0:1]
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Per-lane FIFO status and head word, as seen by the arbiter.
   logic [DATA_W-1:0] head_data [0:1];
   logic              not_empty [0:1];
   logic              pop       [0:1];

   // Output register and round-robin state.
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_lane_q,  out_lane_d;
   logic              out_valid_q, out_valid_d;
   logic              rr_last_q,   rr_last_d;
   logic              load;
   logic              gnt_lane;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [DATA_W-1:0] mem [0:DEPTH-1];
         logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
         logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
         logic [CW-1:0]     cnt_q,    cnt_d;
         logic              ovf_q,    ovf_d;
         logic              full;
         logic              push;
         logic              drop;

         // Fullness is judged on the registered count only, so a pop in the
         // same cycle never makes room for the incoming word.
         assign full = (cnt_q == CW'(DEPTH));
         assign push = in_valid[gi] && !full;
         assign drop = in_valid[gi] && full;

         // Next-state for the pointers, the occupancy count and the sticky overflow flag.
         always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            ovf_d    = ovf_q;
            if (push) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop[gi]) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop[gi]})
               2'b10:   cnt_d = cnt_q + 1'b1;
               2'b01:   cnt_d = cnt_q - 1'b1;
               default: cnt_d = cnt_q;
            endcase
            if (drop) begin
               ovf_d = 1'b1;
            end
         end

         // FIFO control registers, cleared asynchronously.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
               ovf_q    <= 1'b0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               cnt_q    <= cnt_d;
               ovf_q    <= ovf_d;
            end
         end

         // FIFO storage. It is not reset because the count alone defines which entries are valid.
         always_ff @(posedge clk) begin
            if (push) begin
               mem[wr_ptr_q] <= in_data[gi];
            end
         end

         assign head_data[gi] = mem[rd_ptr_q];
         assign not_empty[gi] = (cnt_q != '0);
         assign overflow[gi]  = ovf_q;

`ifdef ARRAY_MERGE_STATS_EN
         logic [15:0] drop_cnt_q, drop_cnt_d;

         // Count the dropped words, saturating at all-ones.
         always_comb begin
            drop_cnt_d = drop_cnt_q;
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end

         // Drop counter register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               drop_cnt_q <= '0;
            end else begin
               drop_cnt_q <= drop_cnt_d;
            end
         end

         assign drop_cnt[gi] = drop_cnt_q;
`endif
      end
   endgenerate

   // Arbitration and output-register next-state. When both lanes are waiting,
   // the lane that was not served last is granted, which gives strict alternation.
   always_comb begin
      load        = !out_valid_q || out_ready;
      gnt_lane    = 1'b0;
      pop[0]      = 1'b0;
      pop[1]      = 1'b0;
      out_data_d  = out_data_q;
      out_lane_d  = out_lane_q;
      out_valid_d = out_valid_q;
      rr_last_d   = rr_last_q;
      if (not_empty[0] && not_empty[1]) begin
         gnt_lane = ~rr_last_q;
      end else begin
         gnt_lane = not_empty[1];
      end
      if (load) begin
         if (not_empty[0] || not_empty[1]) begin
            pop[0]      = !gnt_lane;
            pop[1]      = gnt_lane;
            out_data_d  = gnt_lane ? head_data[1] : head_data[0];
            out_lane_d  = gnt_lane;
            out_valid_d = 1'b1;
            rr_last_d   = gnt_lane;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // Output register. rr_last resets to lane 1 so that lane 0 wins the first contest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_lane_q  <= 1'b0;
         out_valid_q <= 1'b0;
         rr_last_q   <= 1'b1;
      end else begin
         out_data_q  <= out_data_d;
         out_lane_q  <= out_lane_d;
         out_valid_q <= out_valid_d;
         rr_last_q   <= rr_last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_lane  = out_lane_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_bus_merge.sv
// Testbench for array_bus_merge. It drives directed vectors and pushes each
// expected output word ({lane, data}) into a scoreboard queue. A monitor pops
// the queue and compares on every output handshake. Direct checks cover the
// reset values, latency, the overflow flags and, when ARRAY_MERGE_STATS_EN is
// defined, the drop counters.
module tb_array_bus_merge;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] in_data  [0:1];
   logic              in_valid [0:1];
   logic [DATA_W-1:0] out_data;
   logic              out_lane;
   logic              out_valid;
   logic              out_ready;
   logic              overflow [0:1];
`ifdef ARRAY_MERGE_STATS_EN
   logic [15:0]       drop_cnt [0:1];
`endif

   logic [DATA_W:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   array_bus_merge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow)
`ifdef ARRAY_MERGE_STATS_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compares every handshake against the head of the scoreboard.
   task automatic monitor();
      logic [DATA_W:0] e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got lane %0d data %0h, required no output",
                        out_lane, out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_lane, out_data} !== e) begin
                  errors++;
                  $display("FAIL out_word: got lane %0d data %0h, required lane %0d data %0h",
                           out_lane, out_data, e[DATA_W], e[DATA_W-1:0]);
               end else begin
                  $display("xfer lane %0d data %0h", out_lane, out_data);
               end
            end
         end
      end
   endtask

   // Waits for the scoreboard to empty, with a bounded number of cycles.
   task automatic drain(input int max_cycles);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
      end else begin
         $display("ok   drain after %0d cycles", n);
      end
   endtask

   initial begin
      rst         = 1'b1;
      in_data[0]  = '0;
      in_data[1]  = '0;
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
      out_ready   = 1'b0;
      fork
         monitor();
      join_none

      // Reset values
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_lane", out_lane, 0);
      chk("rst_overflow0", overflow[0], 0);
      chk("rst_overflow1", overflow[1], 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single word on lane 0: the word appears after the second edge and is gone after the third.
      out_ready   = 1'b1;
      in_data[0]  = 8'hA5;
      in_valid[0] = 1'b1;
      exp_q.push_back({1'b0, 8'hA5});
      tick();
      in_valid[0] = 1'b0;
      chk("single_no_bypass", out_valid, 0);
      tick();
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 8'hA5);
      chk("single_lane", out_lane, 0);
      tick();
      chk("single_done", out_valid, 0);

      // Reset mid-stream with words buffered in both FIFOs.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data[0]  = 8'(8'h30 + i);
         in_data[1]  = 8'(8'h40 + i);
         in_valid[0] = 1'b1;
         in_valid[1] = 1'b1;
         tick();
      end
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_overflow0", overflow[0], 0);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("post_rst_empty", out_valid, 0);

      // Alternation from reset: lane 0 first, then lane 1 on the next cycle.
      in_data[0]  = 8'h10;
      in_data[1]  = 8'h20;
      in_valid[0] = 1'b1;
      in_valid[1] = 1'b1;
      exp_q.push_back({1'b0, 8'h10});
      exp_q.push_back({1'b1, 8'h20});
      tick();
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
      tick();
      chk("alt_first_data", out_data, 8'h10);
      chk("alt_first_lane", out_lane, 0);
      tick();
      chk("alt_second_data", out_data, 8'h20);
      chk("alt_second_lane", out_lane, 1);
      tick();
      chk("alt_done", out_valid, 0);

      // Backpressure on lane 1: 01 is held in the output register, 02..05 fill the FIFO, 06 is dropped.
      out_ready = 1'b0;
      for (int v = 1; v <= 4; v++) begin
         in_data[1]  = 8'(v);
         in_valid[1] = 1'b1;
         exp_q.push_back({1'b1, 8'(v)});
         tick();
      end
      chk("bp_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h01);
      in_data[1] = 8'h05;
      exp_q.push_back({1'b1, 8'h05});
      tick();
      chk("bp_fill_no_ovf", overflow[1], 0);
      in_data[1] = 8'h06;
      tick();
      in_valid[1] = 1'b0;
      chk("bp_drop_ovf1", overflow[1], 1);
      chk("bp_still_hold", out_data, 8'h01);
      out_ready = 1'b1;
      drain(20);
      chk("bp_ovf1_sticky", overflow[1], 1);
      chk("bp_ovf0_clear", overflow[0], 0);

      // Lane 0 full while it is popped in the same cycle: the new word is still dropped.
      out_ready = 1'b0;
      for (int v = 0; v < 5; v++) begin
         in_data[0]  = 8'(8'hB1 + v);
         in_valid[0] = 1'b1;
         exp_q.push_back({1'b0, 8'(8'hB1 + v)});
         tick();
      end
      chk("full_no_ovf0", overflow[0], 0);
      in_data[0]  = 8'hB6;
      out_ready   = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      chk("full_pop_ovf0", overflow[0], 1);
      chk("full_pop_data", out_data, 8'hB2);
      drain(20);
      tick();
      chk("full_pop_done", out_valid, 0);

`ifdef ARRAY_MERGE_STATS_EN
      // Drop counters: 3 drops on lane 0, then saturation.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("stats_rst", drop_cnt[0], 0);
      out_ready = 1'b0;
      for (int v = 0; v < 5; v++) begin
         in_data[0]  = 8'(8'hC0 + v);
         in_valid[0] = 1'b1;
         exp_q.push_back({1'b0, 8'(8'hC0 + v)});
         tick();
      end
      chk("stats_full_zero", drop_cnt[0], 0);
      in_data[0] = 8'hCF;
      for (int i = 0; i < 3; i++) tick();
      chk("stats_drop0_3", drop_cnt[0], 3);
      chk("stats_drop1_0", drop_cnt[1], 0);
      for (int i = 0; i < 65537; i++) tick();
      in_valid[0] = 1'b0;
      chk("stats_saturate", drop_cnt[0], 16'hFFFF);
      out_ready = 1'b1;
      drain(20);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/array_bus_merge.md
# array_bus_merge

Merges two independent valid-only byte lanes into a single ready/valid stream. It sits directly downstream of the two-lane registered array bus stage, which has no backpressure. Each lane has its own FIFO, a round-robin arbiter drains the FIFOs into one registered output tagged with the source lane, and per-lane sticky overflow flags report data dropped on a full FIFO.

## Interface
- DATA_W, default 8: lane and output data width.
- DEPTH, default 4: per-lane FIFO depth in entries; must be a power of 2 and at least 2.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data[0:1]  input  DATA_W each  lane data, unpacked array.
- in_valid[0:1]  input  1 each  lane data valid; there is no ready, and the lane is never stalled.
- out_data  output  DATA_W  merged data.
- out_lane  output  1  source lane of out_data.
- out_valid  output  1  out_data/out_lane valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- overflow[0:1]  output  1 each  sticky: lane i dropped at least one word.
- drop_cnt[0:1]  output  16 each  present only with ARRAY_MERGE_STATS_EN.

## Operation
- Reset (async assert, sync release): FIFOs empty, out_valid=0, out_data=0, out_lane=0, overflow=0, drop_cnt=0, rr_last=1, so lane 0 has first priority.
- Lane write: when in_valid[i]=1 and FIFO i count < DEPTH, in_data[i] is written at that edge.
- Lane drop: when in_valid[i]=1 and FIFO i count == DEPTH, the word is discarded and overflow[i] is set. This applies even if FIFO i is popped in the same cycle; a same-cycle pop does not free space for the incoming word.
- overflow[i] stays set until rst.
- Output register load condition: load = !out_valid || out_ready.
- When load=1 and at least one FIFO is non-empty:
  - Grant one lane.
  - Pop its head into out_data and write the lane number to out_lane.
  - Set out_valid=1 and set rr_last to the granted lane.
- When load=1 and both FIFOs are empty, out_valid goes to 0.
- When load=0, out_data, out_lane and out_valid hold.
- Arbitration:
  - Only one FIFO non-empty: that lane is granted.
  - Both non-empty: the lane != rr_last is granted (strict alternation).
- A FIFO may be written and popped in the same cycle; its count is unchanged.
- Counts are $clog2(DEPTH)+1 bits wide. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- There is no FIFO bypass: a word written at edge N is first eligible for arbitration in cycle N+1.

## Timing
- Latency: in_valid sampled at edge N appears with out_valid=1 after edge N+1, given an empty path and out_ready=1.
- Throughput: one output word per cycle while out_ready=1. Sustained combined input above 1 word/cycle eventually overflows.
- Backpressure: while out_valid=1 && out_ready=0, the output is stable and no FIFO is popped.
- Reset asserted mid-operation: all state clears immediately (asynchronously), and any in-flight or buffered data is lost. Outputs are at their reset values from the assertion onward.
- Both lanes valid every cycle with out_ready=1:
  - Output alternates 0,1,0,1.
  - Each FIFO gains one word every 2 cycles.
  - Lane overflow occurs after DEPTH fills.

## Configuration
- ARRAY_MERGE_STATS_EN:
  - Defined: adds drop_cnt[0:1] ports. drop_cnt[i] increments on each dropped word of lane i, saturates at 16'hFFFF, and clears on rst.
  - Undefined: the drop_cnt ports and logic are absent. Overflow flags are unaffected.

## Test plan
- Reset: assert rst mid-stream with both FIFOs holding 2 words -> out_valid=0, overflow=0 and rr_last=1 immediately; the next word on either lane emerges with correct latency.
- Single lane: in_data[0]=8'hA5 with in_valid[0]=1 for one cycle at edge N, out_ready=1 -> out_valid=1, out_data=8'hA5, out_lane=0 after edge N+1, and out_valid=0 after edge N+2.
- Alternation: in_data[0]=8'h10, in_data[1]=8'h20, both valid on the same single cycle, out_ready=1 -> outputs 8'h10/lane 0 then 8'h20/lane 1 on consecutive cycles.
- Backpressure: out_ready=0 while lane 1 sends 8'h01..8'h04 (DEPTH=4) -> out_valid=1 holding 8'h01. Lane 1 then sends 8'h05 and 8'h06:
  - FIFO holds 8'h02..8'h04. The output register took 8'h01, so the FIFO is not yet full.
  - 8'h05 fills the FIFO; 8'h06 is dropped and overflow[1]=1.
  - Release out_ready -> sequence 8'h01..8'h05 emerges, and overflow[1] stays 1.
- Full with simultaneous pop: FIFO 0 full, out_ready=1, in_valid[0]=1 -> the word is dropped, overflow[0]=1, and the count drops to DEPTH-1.
- Stats (macro defined): drop 3 words on lane 0 -> drop_cnt[0]=3, drop_cnt[1]=0. Force 65537 drops -> drop_cnt[0]=16'hFFFF.
